// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: frame state encoding (common to the
//               transmitter and receiver) and the default baud timing.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Bit-period counter width and reload value for the system baud rate
    // (reload = clk / baud - 1).
    localparam int         DEFAULT_N    = 5;
    localparam logic [4:0] DEFAULT_FULL = 5'd29;

    // Gray-style encoding shared with the receiver.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        START_BIT = 2'b01,
        SENDING   = 2'b11,
        STOP_BIT  = 2'b10
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter_if
// Description : Byte-write handshake and serial line of the UART transmitter.
//               master = byte producer, slave = transmitter.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_transmitter_if;
    logic [7:0] Data;
    logic       Send;
    logic       Ready;
    logic       Busy;
    logic       Tx;

    modport master (output Data, output Send, input Ready, input Busy, input Tx);
    modport slave  (input Data, input Send, output Ready, output Busy, output Tx);
endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Bit-period down-counter. Load reloads FULL; Tick flags the
//               last clock of the current bit period (count == 0). The count
//               parks at zero instead of wrapping.
// Revision    : 1.0  initial release
// ============================================================================
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int           N    = DEFAULT_N,
    parameter logic [N-1:0] FULL = DEFAULT_FULL[N-1:0]
) (
    input  wire logic Clk,
    input  wire logic Reset,
    input  wire logic Load,
    output logic      Tick
);

    logic [N-1:0] count;

    // Reload at bit start, otherwise count down and hold at zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (Load) begin
            count <= FULL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign Tick = (count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter, idle-high, LSB first, with a one-byte
//               holding register so frames can run back to back.
// Revision    : 1.0  initial release
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int           N    = DEFAULT_N,
    parameter logic [N-1:0] FULL = DEFAULT_FULL[N-1:0]
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    uart_transmitter_if.slave bus
);

    uart_state_t state, state_next;
    logic [7:0]  shift, shift_next;
    logic [7:0]  hold, hold_next;
    logic        hold_full, hold_full_next;
    logic [2:0]  bit_count, bit_count_next;
    logic        tx, tx_next;
    logic        busy;
    logic        timer_load;
    logic        tick;
    logic        accept;

    // A write only lands when the holding register is empty.
    assign accept = bus.Send & ~hold_full;

    uart_bit_timer #(
        .N    (N),
        .FULL (FULL)
    ) u_bit_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (timer_load),
        .Tick  (tick)
    );

    // State, datapath and line registers; reset drives the line high at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_count <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            hold      <= hold_next;
            hold_full <= hold_full_next;
            bit_count <= bit_count_next;
            tx        <= tx_next;
            busy      <= (state_next != IDLE);
        end
    end

    // Next-state logic: byte accept, frame sequencing and holding-register
    // hand-off. Accept and load never coincide since accept needs hold empty.
    always_comb begin
        state_next     = state;
        shift_next     = shift;
        hold_next      = hold;
        hold_full_next = hold_full;
        bit_count_next = bit_count;
        tx_next        = tx;
        timer_load     = 1'b0;

        if (accept) begin
            hold_next      = bus.Data;
            hold_full_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hold_full) begin
                    shift_next     = hold;
                    hold_full_next = 1'b0;
                    tx_next        = 1'b0;
                    timer_load     = 1'b1;
                    state_next     = START_BIT;
                end
            end
            START_BIT: begin
                if (tick) begin
                    tx_next        = shift[0];
                    bit_count_next = 3'd0;
                    timer_load     = 1'b1;
                    state_next     = SENDING;
                end
            end
            SENDING: begin
                if (tick) begin
                    timer_load = 1'b1;
                    if (bit_count == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP_BIT;
                    end else begin
                        shift_next     = shift >> 1;
                        tx_next        = shift[1];
                        bit_count_next = bit_count + 3'd1;
                    end
                end
            end
            STOP_BIT: begin
                if (tick) begin
                    if (hold_full) begin
                        // Chain straight into the next start bit: no idle gap.
                        shift_next     = hold;
                        hold_full_next = 1'b0;
                        tx_next        = 1'b0;
                        timer_load     = 1'b1;
                        state_next     = START_BIT;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign bus.Ready = ~hold_full;
    assign bus.Busy  = busy;
    assign bus.Tx    = tx;

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises bytes onto an asynchronous UART line: 8N1 framing (1 start, 8 data LSB first, 1 stop), idle-high.
- Transmit counterpart of the UART receiver.
- Shares its baud parameterisation (Full = Clk/BAUD - 1).
- Includes a one-byte holding register, so the next byte can be accepted while the current frame is on the wire; back-to-back frames have no idle gap.

Parameters:
N     5      width of the bit-period counter
Full  5'd29  clocks per bit minus 1 (Clk / BAUD - 1); must be >= 1 and < 2^N

Ports:
Clk    input   1  system clock; all logic rising-edge
Reset  input   1  asynchronous, active-high reset
Data   input   8  byte to send; sampled when Send & Ready
Send   input   1  write strobe, synchronous to Clk; accepted only when Ready = 1
Ready  output  1  high = holding register empty, can accept a byte
Busy   output  1  high while a frame is on the line (State != Idle)
Tx     output  1  serial line, registered, idle high

Behaviour:
- Reset (async, any state, mid-frame included):
  - Tx = 1, Ready = 1, Busy = 0.
  - State = Idle; Count, BitCount, Hold, Shift = 0; HoldFull = 0.
  - A partial frame is abandoned; the line returns high immediately.
- States: Idle, StartBit, Sending, StopBit. Busy = (State != Idle), registered.
- Accept:
  - At an edge where Send = 1 and Ready = 1: Hold <= Data, HoldFull <= 1, Ready <= 0.
  - Send while Ready = 0 is ignored: no effect, byte dropped.
- Ready always equals ~HoldFull.
- Idle:
  - If HoldFull: Shift <= Hold, HoldFull <= 0 (Ready <= 1), Tx <= 0, Count <= Full, State <= StartBit.
  - Latency: Send accepted at edge k -> Tx low from edge k+1.
- Bit timing:
  - Each bit occupies exactly Full+1 clocks: Count is loaded with Full at bit start and decrements each clock.
  - The bit ends when Count == 0.
- StartBit end: Tx <= Shift[0], BitCount <= 0, Count <= Full, State <= Sending.
- Sending end:
  - If BitCount == 7: Tx <= 1, Count <= Full, State <= StopBit.
  - Else: Shift <= Shift >> 1, Tx <= next bit, BitCount <= BitCount + 1, Count <= Full.
- StopBit end:
  - If HoldFull: perform the Idle load action directly (Tx <= 0, State <= StartBit); no idle clock between frames.
  - Else State <= Idle, Tx stays 1.
- Simultaneous events:
  - Send accepted on the same edge StopBit ends with HoldFull = 0: byte goes to Hold; Idle loads it on the next edge (one idle clock, Tx high).
  - The Idle/StopBit load and a new accept cannot coincide, because Ready = 0 whenever HoldFull = 1.
- Frame length: 10*(Full+1) clocks (300 at default), start-bit falling edge to end of stop bit.
- BitCount is 3 bits and wraps only under the explicit reload; Count arithmetic is N-bit unsigned, never underflows (reloaded at 0).

Decomposition:
- Shared package uart_pkg:
  - state localparams (Idle = 2'b00, StartBit = 2'b01, Sending = 2'b11, StopBit = 2'b10, same encoding as the receiver);
  - default Full / N for the system baud.
- One natural sub-module: uart_bit_timer.
  - Parameters N, Full. Inputs Clk, Reset, Load; output Tick (Count == 0).
  - Reusable by the receiver later.
- The FSM, holding register and shift register stay in uart_transmitter.

Test Plan:
- Reset then idle 100 clocks -> Tx = 1, Ready = 1, Busy = 0 throughout.
- Send 0xA5 at edge k (Full = 29) -> Tx low edges k+1..k+30, then bits 1,0,1,0,0,1,0,1 each 30 clocks, stop high 30 clocks; Busy high 300 clocks; Ready high again from edge k+1.
- Send 0x00 then, while Busy, Send 0xFF -> second Send accepted (Ready falls); second start bit begins exactly 300 clocks after the first start bit, no gap; Ready stays 0 until that load.
- With Hold full, pulse Send with 0x3C -> ignored; line shows only the two previously queued bytes.
- Assert Reset at clock 120 of a frame -> Tx = 1 asynchronously (same cycle), Ready = 1, Busy = 0; a new Send afterward produces a clean full frame.
- Full = 1, N = 1, send 0x81 -> 20-clock frame, each bit 2 clocks, LSB first.
